// File: rtl/risc_v_pkg.sv
// risc_v_pkg
// Shared RV32I encoding constants used by the instruction encoder and the
// control decoder: the request class enumeration, the seven major opcodes
// and the funct3 values that are fixed by the class rather than supplied by
// the requester.
package risc_v_pkg;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_JALR = 3'd3,
    CLS_B    = 3'd4,
    CLS_JAL  = 3'd5,
    CLS_SW   = 3'd6,
    CLS_ILL  = 3'd7
  } instr_cls_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_SW   = 7'b0100011;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

endpackage

// File: rtl/instr_format_pack.sv
// instr_format_pack
// Combinational packer: turns a decoded request (class, register fields,
// funct3/funct7 and a 21-bit immediate) into a 32-bit RV32I word.
// Ports:
//   cls     in   instruction class
//   rd/rs1/rs2 in 5-bit register fields
//   funct3  in   used for R, I and B only
//   funct7  in   used for R only
//   imm     in   21-bit immediate; bits beyond each format are dropped
//   word    out  encoded instruction (0 for the illegal class)
module instr_format_pack
  import risc_v_pkg::*;
(
  input  instr_cls_e  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [20:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = 32'h0;
    case (cls)
      CLS_R:    word = {funct7, rs2, rs1, funct3, rd, OP_R};
      CLS_I:    word = {imm[11:0], rs1, funct3, rd, OP_I};
      CLS_LW:   word = {imm[11:0], rs1, F3_LW, rd, OP_LW};
      CLS_JALR: word = {imm[11:0], rs1, F3_JALR, rd, OP_JALR};
      CLS_SW:   word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_SW};
      // Branch/jump offsets are halfword aligned, so imm[0] never appears.
      CLS_B:    word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
      CLS_JAL:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default:  word = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Accepts encode requests, packs them into RV32I words and writes them to
// consecutive instruction-memory addresses (wrapping modulo DEPTH). One word
// per three cycles: IDLE (accept) -> PACK (register word) -> WRITE (strobe).
// Optional feature macro: INSTR_ENC_IMM_CHK_EN rejects requests whose
// immediate does not fit the signed (and, for B/JAL, even) range of the format.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake
//   req_cls, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm  fields
//   clear               zero pointer/count, abort any in-flight word
//   imem_we/addr/wdata  instruction-memory write port
//   count, full         words written since reset/clear, count==DEPTH
//   err                 one-cycle pulse after a rejected request
module instr_encoder
  import risc_v_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_cls,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [20:0]       req_imm,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_WRITE} state_e;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  instr_cls_e        cls_q, cls_d;
  logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]        f3_q, f3_d;
  logic [6:0]        f7_q, f7_d;
  logic [20:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d, err_q, err_d;
  logic              accept, reject, imm_ok;
  logic [31:0]       packed_word;

  instr_format_pack u_pack (
    .cls    (cls_q),
    .rd     (rd_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .funct3 (f3_q),
    .funct7 (f7_q),
    .imm    (imm_q),
    .word   (packed_word)
  );

`ifdef INSTR_ENC_IMM_CHK_EN
  // Signed fit test: all bits from the format's sign bit upward must agree.
  always_comb begin
    imm_ok = 1'b1;
    case (instr_cls_e'(req_cls))
      CLS_I, CLS_LW, CLS_JALR, CLS_SW:
        imm_ok = (&req_imm[20:11]) | ~(|req_imm[20:11]);
      CLS_B:
        imm_ok = ((&req_imm[20:12]) | ~(|req_imm[20:12])) & ~req_imm[0];
      CLS_JAL:
        imm_ok = ~req_imm[0];
      default:
        imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign full      = (count_q == DEPTH_W);
  assign req_ready = (state_q == S_IDLE) && !full;
  // clear wins over a simultaneous request.
  assign accept    = req_valid && req_ready && !clear;
  assign reject    = accept && ((instr_cls_e'(req_cls) == CLS_ILL) || !imm_ok);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    imm_d   = imm_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cls_d = instr_cls_e'(req_cls);
          rd_d  = req_rd;
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          f3_d  = req_funct3;
          f7_d  = req_funct7;
          imm_d = req_imm;
          err_d = reject;
          if (!reject) state_d = S_PACK;
        end
      end
      S_PACK: begin
        wdata_d = packed_word;
        addr_d  = ptr_q;
        we_d    = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      count_d = '0;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_R;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      imm_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      imm_q   <= imm_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // A clear landing in the WRITE cycle drops the word already on the bus.
  assign imem_we    = we_q && !clear;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
- REQ-001 Parameter: DEPTH, default 256, number of 32-bit instruction-memory words; power of two, at least 2.
- REQ-002 Parameter: ADDR_W, default $clog2(DEPTH), instruction-memory word-address width.
- REQ-003 Clock and reset are fixed: one clock, and reset is synchronous and active-low.
- REQ-004 Port list, clock and reset first:
  - clk  in  1  single clock; all logic on posedge.
  - rst_n  in  1  synchronous active-low reset.
  - req_valid  in  1  encode request present.
  - req_ready  out  1  block can accept a request.
  - req_cls  in  3  0=R, 1=I, 2=LW, 3=JALR, 4=B, 5=JAL, 6=SW, 7=illegal.
  - req_rd, req_rs1, req_rs2  in  5 each  register fields.
  - req_funct3  in  3  funct3 for R/I/B.
  - req_funct7  in  7  funct7 for R.
  - req_imm  in  21  signed immediate, byte offset for B/J.
  - clear  in  1  reset write pointer and count.
  - imem_we  out  1  instruction-memory write strobe.
  - imem_addr  out  ADDR_W  word address.
  - imem_wdata  out  32  encoded instruction.
  - count  out  ADDR_W+1  words written since reset or clear.
  - full  out  1  count equals DEPTH.
  - err  out  1  one-cycle pulse on a rejected request.

Function
- REQ-005 The FSM has three states: IDLE, PACK and WRITE; req_ready is 1 only in IDLE with full=0.
- REQ-006 A request is accepted when req_valid and req_ready are both 1; all request fields are registered at acceptance.
- REQ-007 In IDLE, an accepted legal request moves the FSM to PACK; in PACK, the word is registered and the FSM moves to WRITE; in WRITE, imem_we=1 for exactly one cycle, then the FSM returns to IDLE.
- REQ-008 Latency: acceptance in cycle N gives imem_we in cycle N+2; sustained throughput is one word per 3 cycles.
- REQ-009 Opcode per class: R=0110011, I=0010011, LW=0000011, JALR=1100111, B=1100011, JAL=1101111, SW=0100011.
- REQ-010 Formats:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I, LW, JALR: imm[11:0]|rs1|f3|rd|op.
  - SW: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- REQ-011 funct3 is forced to 010 for LW and SW and to 000 for JALR; req_funct3 is used for R, I and B only.
- REQ-012 imm[0] is ignored for B and JAL; immediate bits above each format's range are ignored.
- REQ-013 imem_addr equals the write pointer during WRITE; the pointer and count increment after each write; the pointer wraps modulo DEPTH.
- REQ-014 Once count reaches DEPTH, full=1 and req_ready=0 until clear or reset; no write occurs while full.
- REQ-015 An accepted request with req_cls=7 produces err=1 in the next cycle, no write and no count change; the FSM stays in IDLE.
- REQ-016 clear=1 in any state sets the pointer and count to 0 and the FSM to IDLE; an in-flight word is dropped and imem_we stays 0 that cycle.
- REQ-017 When clear and req_valid are both 1 in the same cycle, clear has priority and the request is not accepted.
- REQ-018 imem_we=0 and err=0 in every cycle not covered by REQ-007 and REQ-015.

Reset
- REQ-019 When rst_n=0 at posedge: FSM to IDLE; pointer, count, imem_we, imem_addr, imem_wdata and err all 0; full=0; req_ready=1 from the first cycle after reset.
- REQ-020 Reset mid-operation aborts any pending write without asserting imem_we.

Configuration
- REQ-021 Macro INSTR_ENC_IMM_CHK_EN enables an immediate range check.
  - Defined: a request whose req_imm does not fit the signed range of its format (12-bit for I/LW/JALR/SW, 13-bit even for B, 21-bit even for JAL) is rejected as in REQ-015.
  - Undefined: no check; the immediate is truncated per REQ-012.

Structure
- REQ-022 Shared package risc_v_pkg holds the class enumeration, the seven opcode constants and the forced funct3 constants, shared with the control decoder.
- REQ-023 A combinational sub-module instr_format_pack (class, fields, imm in; 32-bit word out) holds REQ-009 to REQ-012; the FSM, pointer and range check stay in instr_encoder.

Verification
- REQ-024 R, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> imem_wdata=0x002081B3 at addr 0, two cycles after acceptance.
- REQ-025 I, rd=5, rs1=0, f3=0, imm=-1 -> 0xFFF00293; then SW, rs1=1, rs2=2, imm=8 -> 0x0020A423 at addr 1.
- REQ-026 JAL, rd=1, imm=8 -> 0x008000EF; B, rs1=1, rs2=2, f3=0, imm=-4 -> 0xFE208EE3.
- REQ-027 DEPTH=4: four legal writes -> full=1, count=4, req_ready=0; a fifth req_valid is held, with no write, until clear -> count=0, next write at addr 0.
- REQ-028 req_cls=7 -> err pulse of one cycle, imem_we=0, count unchanged; with the macro defined, I with imm=2048 -> err, no write.
- REQ-029 clear asserted in the PACK cycle -> no imem_we, count=0, FSM in IDLE next cycle.
